// File: rtl/delta_enc_pkg.sv
// Shared types and helpers for the multi-channel delta-modulation spike encoder.
// Event polarity, the event record and the threshold compare live here.
package delta_enc_pkg;

   parameter int unsigned CH_W = 2;

   typedef enum logic {
      POL_OFF = 1'b0,
      POL_ON  = 1'b1
   } pol_e;

   typedef struct packed {
      logic [CH_W-1:0] ch;
      pol_e            pol;
   } spike_evt_t;

   // A zero magnitude never spikes, even with a zero threshold.
   function automatic logic thr_hit(input logic [31:0] mag, input logic [31:0] thr);
      return (mag != 32'd0) && (mag >= thr);
   endfunction

endpackage

// File: rtl/delta_event_fifo.sv
// Synchronous spike-event FIFO with registered storage and wrap-bit pointers.
// dout shows the head entry and stays stable until it is popped.
module delta_event_fifo
   import delta_enc_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter type         evt_t = spike_evt_t
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  evt_t din,
   output logic full,
   input  logic pop,
   output logic empty,
   output evt_t dout
);

   localparam int unsigned AW = $clog2(DEPTH);

   evt_t        mem_q [DEPTH];
   logic [AW:0] wr_q;
   logic [AW:0] rd_q;
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= din;
            wr_q                <= wr_q + (AW+1)'(1);
         end
         if (do_pop) begin
            rd_q <= rd_q + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/delta_spike_encoder.sv
// Multi-channel delta-modulation spike encoder: per-channel prev reference, ON/OFF events into a FIFO.
// Optional DELTA_OFF_SPIKE_EN adds a per-channel mask for OFF events.
module delta_spike_encoder
   import delta_enc_pkg::*;
#(
   parameter  int unsigned N_CH       = 4,
   parameter  int unsigned DATA_W     = 8,
   parameter  int unsigned FIFO_DEPTH = 4,
   localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] thr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CH_W-1:0]   in_ch,
   input  logic [DATA_W-1:0] in_data,
   input  logic              load_valid,
   input  logic [CH_W-1:0]   load_ch,
   input  logic [DATA_W-1:0] load_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CH_W-1:0]   out_ch,
   output logic              out_pol,
   input  logic [CH_W-1:0]   prev_rd_ch,
   output logic [DATA_W-1:0] prev_rd_data
`ifdef DELTA_OFF_SPIKE_EN
   ,
   input  logic [N_CH-1:0]   off_spike_en
`endif
);

   typedef struct packed {
      logic [CH_W-1:0] ch;
      pol_e            pol;
   } evt_t;

   logic [DATA_W-1:0]     prev_q [N_CH];
   logic [DATA_W-1:0]     prev_d [N_CH];
   logic [DATA_W-1:0]     prev_sel;
   logic                  in_hit;
   logic                  off_en;
   logic signed [DATA_W:0] diff;
   logic [DATA_W:0]       mag;
   pol_e                  pol;
   logic                  spike;
   logic                  accept;
   logic                  sample_upd;
   logic                  push;
   evt_t                  push_evt;
   evt_t                  head_evt;
   logic                  fifo_full;
   logic                  fifo_empty;

   // Out-of-range channels never match, so they read as no-hit and select zero.
   always_comb begin
      prev_sel     = '0;
      in_hit       = 1'b0;
      off_en       = 1'b0;
      prev_rd_data = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (in_ch == CH_W'(c)) begin
            prev_sel = prev_q[c];
            in_hit   = 1'b1;
`ifdef DELTA_OFF_SPIKE_EN
            off_en   = off_spike_en[c];
`else
            off_en   = 1'b1;
`endif
         end
         if (prev_rd_ch == CH_W'(c)) begin
            prev_rd_data = prev_q[c];
         end
      end
   end

   always_comb begin
      diff       = $signed({1'b0, in_data}) - $signed({1'b0, prev_sel});
      mag        = diff[DATA_W] ? $unsigned(-diff) : $unsigned(diff);
      pol        = diff[DATA_W] ? POL_OFF : POL_ON;
      spike      = thr_hit(32'(mag), 32'(thr));
      accept     = in_valid && !fifo_full;
      sample_upd = accept && in_hit && spike;
      // A masked OFF still moves the reference but never occupies the FIFO.
      push       = sample_upd && ((pol == POL_ON) || off_en);
      push_evt   = '{ch: in_ch, pol: pol};
   end

   // Load is applied after the sample update so it wins a same-channel collision.
   always_comb begin
      prev_d = prev_q;
      for (int c = 0; c < N_CH; c++) begin
         if (sample_upd && (in_ch == CH_W'(c))) begin
            prev_d[c] = in_data;
         end
         if (load_valid && (load_ch == CH_W'(c))) begin
            prev_d[c] = load_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < N_CH; c++) begin
            prev_q[c] <= '0;
         end
      end else begin
         prev_q <= prev_d;
      end
   end

   delta_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .evt_t (evt_t)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (push_evt),
      .full  (fifo_full),
      .pop   (out_ready),
      .empty (fifo_empty),
      .dout  (head_evt)
   );

   assign in_ready  = !fifo_full;
   assign out_valid = !fifo_empty;
   assign out_ch    = head_evt.ch;
   assign out_pol   = head_evt.pol;

endmodule

// File: tb/tb_delta_spike_encoder.sv
// Directed self-checking bench for delta_spike_encoder (N_CH=4, DATA_W=8, FIFO_DEPTH=4).
// Define DELTA_OFF_SPIKE_EN to also exercise the OFF-event mask.
module tb_delta_spike_encoder;

   logic       clk;
   logic       rst_n;
   logic [7:0] thr;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_ch;
   logic [7:0] in_data;
   logic       load_valid;
   logic [1:0] load_ch;
   logic [7:0] load_data;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_ch;
   logic       out_pol;
   logic [1:0] prev_rd_ch;
   logic [7:0] prev_rd_data;
`ifdef DELTA_OFF_SPIKE_EN
   logic [3:0] off_spike_en;
`endif

   int vectors;
   int miscompares;

   delta_spike_encoder #(
      .N_CH       (4),
      .DATA_W     (8),
      .FIFO_DEPTH (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .thr          (thr),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_ch        (in_ch),
      .in_data      (in_data),
      .load_valid   (load_valid),
      .load_ch      (load_ch),
      .load_data    (load_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_ch       (out_ch),
      .out_pol      (out_pol),
      .prev_rd_ch   (prev_rd_ch),
      .prev_rd_data (prev_rd_data)
`ifdef DELTA_OFF_SPIKE_EN
      ,
      .off_spike_en (off_spike_en)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] ch, input logic [7:0] data);
      in_valid = 1'b1;
      in_ch    = ch;
      in_data  = data;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic pop_one();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic check_prev(input string tag, input logic [1:0] ch, input logic [7:0] exp);
      prev_rd_ch = ch;
      #1;
      check(tag, 32'(prev_rd_data), 32'(exp));
   endtask

   task automatic check_evt(input string tag, input logic [1:0] ch, input logic pol);
      check({tag, ".valid"}, 32'(out_valid), 32'd1);
      check({tag, ".ch"}, 32'(out_ch), 32'(ch));
      check({tag, ".pol"}, 32'(out_pol), 32'(pol));
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      thr         = 8'd10;
      in_valid    = 1'b0;
      in_ch       = '0;
      in_data     = '0;
      load_valid  = 1'b0;
      load_ch     = '0;
      load_data   = '0;
      out_ready   = 1'b0;
      prev_rd_ch  = '0;
`ifdef DELTA_OFF_SPIKE_EN
      off_spike_en = 4'b0000;
`endif
      #2;
      check("rst.out_valid", 32'(out_valid), 32'd0);
      check("rst.in_ready", 32'(in_ready), 32'd1);
      check("rst.out_ch", 32'(out_ch), 32'd0);
      check("rst.out_pol", 32'(out_pol), 32'd0);
      check_prev("rst.prev2", 2'd2, 8'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // thr=10 on ch2: 15 -> ON, 9 -> nothing, 4 -> OFF
      send(2'd2, 8'd15);
      check_evt("t1.on", 2'd2, 1'b1);
      check_prev("t1.prev15", 2'd2, 8'd15);
      pop_one();
      check("t1.drained", 32'(out_valid), 32'd0);
      send(2'd2, 8'd9);
      check("t1.noevt", 32'(out_valid), 32'd0);
      check_prev("t1.prev_kept", 2'd2, 8'd15);
      send(2'd2, 8'd4);
      check_evt("t1.off", 2'd2, 1'b0);
      check_prev("t1.prev4", 2'd2, 8'd4);
      pop_one();

      // thr=0: equal samples never spike, any nonzero diff does
      thr = 8'd0;
      send(2'd1, 8'd0);
      check("t2.zero_a", 32'(out_valid), 32'd0);
      send(2'd1, 8'd0);
      check("t2.zero_b", 32'(out_valid), 32'd0);
      send(2'd1, 8'd1);
      check_evt("t2.on", 2'd1, 1'b1);
      pop_one();
      check_prev("t2.prev1", 2'd1, 8'd1);

      // Fill the FIFO with out_ready low, then free one slot
      thr = 8'd10;
      send(2'd0, 8'd200);
      send(2'd1, 8'd200);
      send(2'd2, 8'd200);
      check("t3.ready_3", 32'(in_ready), 32'd1);
      send(2'd3, 8'd200);
      check("t3.full", 32'(in_ready), 32'd0);
      in_valid = 1'b1;
      in_ch    = 2'd0;
      in_data  = 8'd50;
      tick();
      check("t3.held_ready", 32'(in_ready), 32'd0);
      check_prev("t3.held_prev", 2'd0, 8'd200);
      check_evt("t3.head", 2'd0, 1'b1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t3.ready_after_pop", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check("t3.full_again", 32'(in_ready), 32'd0);
      check_prev("t3.prev50", 2'd0, 8'd50);
      check_evt("t3.q1", 2'd1, 1'b1);
      pop_one();
      check_evt("t3.q2", 2'd2, 1'b1);
      pop_one();
      check_evt("t3.q3", 2'd3, 1'b1);
      pop_one();
      check_evt("t3.q4", 2'd0, 1'b0);
      pop_one();
      check("t3.empty", 32'(out_valid), 32'd0);

      // Loads: plain, same-channel collision, different channels
      load_valid = 1'b1;
      load_ch    = 2'd3;
      load_data  = 8'd0;
      tick();
      load_valid = 1'b0;
      check("t4.load_noevt", 32'(out_valid), 32'd0);
      check_prev("t4.prev3_zero", 2'd3, 8'd0);
      load_valid = 1'b1;
      load_ch    = 2'd3;
      load_data  = 8'd100;
      send(2'd3, 8'd50);
      load_valid = 1'b0;
      check_evt("t4.same", 2'd3, 1'b1);
      check_prev("t4.load_wins", 2'd3, 8'd100);
      pop_one();
      load_valid = 1'b1;
      load_ch    = 2'd0;
      load_data  = 8'd7;
      send(2'd1, 8'd100);
      load_valid = 1'b0;
      check_evt("t4.diff_ch", 2'd1, 1'b0);
      check_prev("t4.prev0_loaded", 2'd0, 8'd7);
      check_prev("t4.prev1_sampled", 2'd1, 8'd100);
      pop_one();

      // Head holds under backpressure, then asynchronous reset clears everything
      send(2'd0, 8'd200);
      send(2'd1, 8'd0);
      send(2'd2, 8'd100);
      tick();
      check_evt("t5.hold", 2'd0, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5.rst_valid", 32'(out_valid), 32'd0);
      check("t5.rst_ready", 32'(in_ready), 32'd1);
      for (int c = 0; c < 4; c++) begin
         check_prev("t5.rst_prev", 2'(c), 8'd0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

`ifdef DELTA_OFF_SPIKE_EN
      // Masked OFF moves prev without an event; unmasked OFF is emitted
      off_spike_en = 4'b0000;
      load_valid   = 1'b1;
      load_ch      = 2'd0;
      load_data    = 8'd50;
      tick();
      load_valid   = 1'b0;
      send(2'd0, 8'd20);
      check("t6.masked", 32'(out_valid), 32'd0);
      check_prev("t6.prev20", 2'd0, 8'd20);
      off_spike_en = 4'b0001;
      send(2'd0, 8'd5);
      check_evt("t6.off", 2'd0, 1'b0);
      pop_one();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/delta_spike_encoder.md
Name: delta_spike_encoder

Overview:
- Multi-channel delta-modulation spike encoder; parametrised successor of the single-channel 4-bit delta modulator.
- Takes time-multiplexed unsigned samples tagged with a channel index and keeps one "prev" reference per channel.
- Emits ON/OFF spike events into an internal event FIFO, drained with a valid/ready handshake.
- Sits between a sample source (ADC/sequencer) and the chip output mux.

Parameters:
- N_CH, 4, number of channels (>=1)
- DATA_W, 8, sample/threshold/prev width, unsigned
- FIFO_DEPTH, 4, event FIFO entries (power of 2, >=2)
- CH_W (localparam), max(1, $clog2(N_CH)), channel index width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- thr  in  DATA_W  global spike threshold, sampled on acceptance
- in_valid  in  1  sample valid
- in_ready  out  1  sample ready; = !fifo_full
- in_ch  in  CH_W  sample channel
- in_data  in  DATA_W  sample value
- load_valid  in  1  force-prev strobe; always accepted
- load_ch  in  CH_W  channel to force
- load_data  in  DATA_W  forced prev value
- out_valid  out  1  event available
- out_ready  in  1  consumer accepts event
- out_ch  out  CH_W  event channel
- out_pol  out  1  1 = ON (up), 0 = OFF (down)
- prev_rd_ch  in  CH_W  readback select
- prev_rd_data  out  DATA_W  combinational prev[prev_rd_ch]; 0 if index >= N_CH

Behaviour:
- Reset (async assert, sync deassert handled upstream): all prev = 0, FIFO empty, out_valid = 0, in_ready = 1, out_ch/out_pol = 0.
- Acceptance: sample accepted when in_valid && in_ready at the rising edge. Compute diff = in_data - prev[in_ch] as signed DATA_W+1 (no wrap).
- Spike rules:
  - diff > 0 && diff >= thr: ON event, prev <= in_data.
  - diff < 0 && -diff >= thr: OFF event, prev <= in_data.
  - Otherwise: no event, prev unchanged.
  - thr = 0: any nonzero diff spikes; diff = 0 never spikes.
- Latency: event pushed at the acceptance edge; out_valid high the next cycle if the FIFO was empty. No combinational bypass.
- FIFO:
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle are both allowed, including when full, but in_ready stays registered-low while full, so no push occurs when full.
  - in_ready rises the cycle after the pop that frees a slot.
  - Ordering is strict FIFO.
- Load:
  - load_valid writes prev[load_ch] = load_data; no event.
  - Same-cycle sample on the same channel: comparison uses the old prev and its event is still emitted, but load_data wins the prev write.
  - Different channels: both take effect.
- Out-of-range in_ch or load_ch (>= N_CH): sample is consumed (in_ready honoured) with no event and no state change; load is ignored.
- out_ch/out_pol hold their value while out_valid && !out_ready.
- Reset mid-operation: FIFO contents and prev are discarded immediately.

Optional Feature:
- DELTA_OFF_SPIKE_EN defined: adds input port off_spike_en [N_CH-1:0]. OFF events for channel c are generated only when off_spike_en[c] = 1. When the bit is 0, an OFF-qualifying sample still updates prev but pushes nothing, and does not consume a FIFO slot.
- Undefined: port absent; OFF events always generated.

Decomposition:
- Package delta_enc_pkg:
  - pol_e enum (POL_OFF = 0, POL_ON = 1)
  - spike_evt_t struct {ch, pol}, parametrised by CH_W via package parameter default 2
  - helper function for the threshold compare
- Sub-module delta_event_fifo:
  - Generic synchronous FIFO of spike_evt_t, depth FIFO_DEPTH.
  - Ports: push/full/pop/empty/dout.
  - Top keeps the prev array, compare logic and load arbitration.

Test Plan (N_CH=4, DATA_W=8, FIFO_DEPTH=4):
- thr=10, prev[2]=0; samples ch2: 15, 9, 4 -> events (2,ON) then (2,OFF); prev[2] = 15 then 15 then 4; no event for 9.
- thr=0; ch1 sample 0 twice then 1 -> no events, then one (1,ON) the cycle after acceptance.
- out_ready=0, four spiking samples on ch0..3 -> in_ready low after the 4th acceptance; 5th sample held. Then out_ready=1 for one cycle -> (0,ON) popped, in_ready high next cycle, 5th accepted; order preserved.
- Same cycle: load ch3 = 100 and sample ch3 = 50 with prev[3] = 0, thr = 10 -> event (3,ON), prev_rd_data(ch3) = 100.
- rst_n pulsed low with 3 events queued and prev set -> out_valid = 0, in_ready = 1, all prev readback = 0 without a clock edge.
- DELTA_OFF_SPIKE_EN defined, off_spike_en = 0, ch0 prev = 50, sample 20, thr = 10 -> no event, prev[0] = 20; set bit, sample 5 -> (0,OFF).
